// File: rtl/bfm_apb_slave_mem_pkg.sv
// -----------------------------------------------------------------------------
// bfm_apb_slave_mem_pkg
// Shared definitions for the APB3 slave memory BFM:
//   - FSM state encoding (IDLE=0, ACCESS=1)
//   - top bit of the local decode window (bit 23; PADDR[31:24] belongs to the
//     bridge decoder)
//   - statistics counter width and wait-counter width
//   - helpers: decode error mask and saturating increment
// -----------------------------------------------------------------------------
package bfm_apb_slave_mem_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam int DEC_TOP_BIT = 23;
  localparam int STAT_W      = 16;
  localparam int CTR_W       = 4;   // holds WAIT_CYCLES 0..15

  // Bits of PADDR that must be zero for a legal access: the byte offset
  // [1:0] and everything in the window above the word index, [23:aw+2].
  function automatic logic [31:0] err_mask(input int aw);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b <= DEC_TOP_BIT; b++)
      if (b < 2 || b >= aw + 2) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bfm_apbslv_waitctr.sv
// -----------------------------------------------------------------------------
// bfm_apbslv_waitctr
// Loadable down-counter for the access-phase wait states.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   load_i  : load WAIT_CYCLES (setup phase)
//   en_i    : decrement by one (stops at zero)
//   done_o  : registered terminal flag, high while the count equals 1, i.e.
//             the next enabled edge is the one that raises PREADY
// -----------------------------------------------------------------------------
module bfm_apbslv_waitctr
  import bfm_apb_slave_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [CTR_W-1:0] LOAD_VAL = CTR_W'(WAIT_CYCLES);

  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = LOAD_VAL;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
    // Flag is registered from the next count so it lines up with cnt_q.
    done_d = (cnt_d == CTR_W'(1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/bfm_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// bfm_apb_slave_mem
// Behavioural APB3 slave memory: 2**AWIDTH x 32-bit word RAM, fixed number of
// access-phase wait states, PSLVERR for out-of-window or misaligned accesses.
//
// Ports
//   HCLK, HRESET          : clock, synchronous active-high reset
//   PSEL, PENABLE, PWRITE : APB control (PSEL is one bit of the bridge vector)
//   PADDR, PWDATA         : byte address, write data
//   PRDATA, PREADY,
//   PSLVERR               : registered response
//   RD_COUNT, WR_COUNT,
//   ERR_COUNT             : saturating transfer statistics, only present when
//                           BFM_APBSLV_STATS_EN is defined
//
// Parameters
//   AWIDTH      : word-index width (valid 1..21)
//   WAIT_CYCLES : wait states before PREADY (0..15)
//   TPD         : output delay for delay-annotating simulation only; the
//                 outputs here are plain zero-delay registers
// -----------------------------------------------------------------------------
module bfm_apb_slave_mem
  import bfm_apb_slave_mem_pkg::*;
#(
  parameter int AWIDTH      = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int TPD         = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
`ifdef BFM_APBSLV_STATS_EN
  ,
  output logic [STAT_W-1:0] RD_COUNT,
  output logic [STAT_W-1:0] WR_COUNT,
  output logic [STAT_W-1:0] ERR_COUNT
`endif
);

  localparam int          DEPTH    = 2 ** AWIDTH;
  localparam logic [31:0] ERR_MASK = err_mask(AWIDTH);

  // Negative delays have no meaning; no hardware is generated either way.
  if (TPD < 0) begin : g_tpd_negative
  end

  // Contents start at zero once; reset deliberately leaves them alone.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [31:0]       prdata_q, prdata_d;

  logic              ctr_load, ctr_en, ctr_done;
  logic              mem_we, xfer_done;

  logic [AWIDTH-1:0] idx_dec;
  logic              err_dec;

  assign idx_dec = PADDR[AWIDTH+1:2];
  assign err_dec = |(PADDR & ERR_MASK);

  bfm_apbslv_waitctr #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_waitctr (
    .clk_i  (HCLK),
    .rst_i  (HRESET),
    .load_i (ctr_load),
    .en_i   (ctr_en),
    .done_o (ctr_done)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    wr_d      = wr_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    mem_we    = 1'b0;
    xfer_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // PENABLE already high here is a protocol violation and is ignored.
        if (PSEL && !PENABLE) begin
          idx_d   = idx_dec;
          err_d   = err_dec;
          wr_d    = PWRITE;
          state_d = ST_ACCESS;
          if (WAIT_CYCLES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = err_dec;
          end else begin
            ctr_load = 1'b1;
          end
          // Read data is fetched at setup so it is stable for the whole access.
          if (!PWRITE)
            prdata_d = err_dec ? '0 : mem_q[idx_dec];
        end
      end

      ST_ACCESS: begin
        if (!pready_q) begin
          if (!PSEL) begin
            state_d = ST_IDLE;
          end else begin
            ctr_en = 1'b1;
            if (ctr_done) begin
              pready_d  = 1'b1;
              pslverr_d = err_q;
            end
          end
        end else if (PSEL && PENABLE) begin
          xfer_done = 1'b1;
          mem_we    = wr_q && !err_q;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Reset on the completion edge suppresses the write.
  always_ff @(posedge HCLK) begin
    if (!HRESET && mem_we)
      mem_q[idx_q] <= PWDATA;
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

`ifdef BFM_APBSLV_STATS_EN
  logic [STAT_W-1:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  // Error transfers are counted both as errors and as reads/writes.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (xfer_done) begin
      if (wr_q) wr_cnt_q <= sat_inc(wr_cnt_q);
      else      rd_cnt_q <= sat_inc(rd_cnt_q);
      if (err_q) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign RD_COUNT  = rd_cnt_q;
  assign WR_COUNT  = wr_cnt_q;
  assign ERR_COUNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_bfm_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_bfm_apb_slave_mem
// Two slaves on one APB bus (WAIT_CYCLES=0 and 3, AWIDTH=8). Directed and
// randomized transfers are checked against an array-based memory model.
// -----------------------------------------------------------------------------
module tb_bfm_apb_slave_mem;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  psel;
  logic [31:0] paddr, pwdata;
  logic        pwrite, penable;

  logic [1:0][31:0] prdata;
  logic [1:0]       pready, pslverr;
`ifdef BFM_APBSLV_STATS_EN
  logic [1:0][15:0] rdc, wrc, erc;
`endif

  always #5 HCLK = ~HCLK;

  bfm_apb_slave_mem #(.AWIDTH(8), .WAIT_CYCLES(0), .TPD(1)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .PSEL(psel[0]), .PADDR(paddr),
    .PWRITE(pwrite), .PENABLE(penable), .PWDATA(pwdata),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
`ifdef BFM_APBSLV_STATS_EN
    , .RD_COUNT(rdc[0]), .WR_COUNT(wrc[0]), .ERR_COUNT(erc[0])
`endif
  );

  bfm_apb_slave_mem #(.AWIDTH(8), .WAIT_CYCLES(3), .TPD(1)) u_dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .PSEL(psel[1]), .PADDR(paddr),
    .PWRITE(pwrite), .PENABLE(penable), .PWDATA(pwdata),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
`ifdef BFM_APBSLV_STATS_EN
    , .RD_COUNT(rdc[1]), .WR_COUNT(wrc[1]), .ERR_COUNT(erc[1])
`endif
  );

  // Reference model
  logic [31:0] rmem [2][256];
  logic [31:0] last_rd [2];
  int          m_rd [2], m_wr [2], m_er [2];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int wc(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      last_rd[u] = '0;
      m_rd[u] = 0; m_wr[u] = 0; m_er[u] = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge HCLK); #1;
    HRESET = 1'b1; psel = '0; penable = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    model_reset();
  endtask

  // Full APB transfer on slave u; checks latency, response and data.
  task automatic xfer(input int u, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit err;
    int idx, cyc;
    bit got;
    err = (a[23:10] != 0) || (a[1:0] != 0);
    idx = int'(a[9:2]);
    @(posedge HCLK); #1;
    psel = '0; psel[u] = 1'b1; paddr = a; pwrite = wr; pwdata = d; penable = 1'b0;
    @(posedge HCLK); #1;
    penable = 1'b1;
    // Setup-phase values must win over anything seen during access.
    paddr = $urandom; pwrite = ~wr;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge HCLK);
      cyc++;
      got = pready[u];
    end
    chk($sformatf("latency u%0d", u), 32'(cyc), 32'(wc(u) + 1));
    chk($sformatf("pslverr u%0d a=%h", u, a), {31'd0, pslverr[u]}, {31'd0, err});
    if (!wr) last_rd[u] = err ? 32'd0 : rmem[u][idx];
    chk($sformatf("prdata u%0d a=%h", u, a), prdata[u], last_rd[u]);
    @(posedge HCLK); #1;
    psel = '0; penable = 1'b0;
    if (wr && !err) rmem[u][idx] = d;
    if (wr) m_wr[u]++; else m_rd[u]++;
    if (err) m_er[u]++;
    @(negedge HCLK);
    chk($sformatf("pready drop u%0d", u), {31'd0, pready[u]}, 32'd0);
  endtask

  // Reset hits during the access phase of a write to index 7.
  task automatic reset_mid_write(input int u);
    @(posedge HCLK); #1;
    psel = '0; psel[u] = 1'b1; paddr = 32'h1C; pwrite = 1'b1;
    pwdata = 32'hA5A5_A5A5; penable = 1'b0;
    @(posedge HCLK); #1;
    penable = 1'b1; HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0; psel = '0; penable = 1'b0;
    model_reset();
    @(negedge HCLK);
    chk($sformatf("rst pready u%0d", u), {31'd0, pready[u]}, 32'd0);
    chk($sformatf("rst prdata u%0d", u), prdata[u], 32'd0);
    xfer(u, 1'b0, 32'h1C, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int u, kind;
    bit wr;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) rmem[i][j] = '0;
    HRESET = 1'b1; psel = '0; paddr = '0; pwrite = 1'b0; penable = 1'b0; pwdata = '0;
    model_reset();
    do_reset();

    @(negedge HCLK);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset prdata u%0d", i), prdata[i], 32'd0);
      chk($sformatf("reset pready u%0d", i), {31'd0, pready[i]}, 32'd0);
      chk($sformatf("reset pslverr u%0d", i), {31'd0, pslverr[i]}, 32'd0);
    end

    // Directed cases
    xfer(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h0000_0010, 32'd0);
    xfer(1, 1'b0, 32'h0000_0004, 32'd0);
    xfer(0, 1'b1, 32'h0000_0400, 32'h1234_5678);
    xfer(0, 1'b0, 32'h0000_0000, 32'd0);
    xfer(0, 1'b0, 32'h0000_0002, 32'd0);
    xfer(1, 1'b1, 32'hFF00_0008, 32'h0BAD_F00D);   // top byte ignored
    xfer(1, 1'b0, 32'h0000_0008, 32'd0);

    // Reset during access phase, with a known old value at index 7
    xfer(0, 1'b1, 32'h1C, 32'h1111_0000);
    xfer(1, 1'b1, 32'h1C, 32'h1111_0003);
    reset_mid_write(0);
    reset_mid_write(1);

    // PENABLE high while idle: no response
    @(posedge HCLK); #1;
    psel = 2'b01; penable = 1'b1; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("idle penable pready", {31'd0, pready[0]}, 32'd0);
    end
    @(posedge HCLK); #1;
    psel = '0; penable = 1'b0;
    xfer(0, 1'b0, 32'h24, 32'd0);

    // PSEL dropped mid-access on the waited slave: no write
    @(posedge HCLK); #1;
    psel = 2'b10; paddr = 32'h20; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; penable = 1'b0;
    @(posedge HCLK); #1;
    penable = 1'b1;
    @(posedge HCLK); #1;
    psel = '0; penable = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("abort pready", {31'd0, pready[1]}, 32'd0);
    xfer(1, 1'b0, 32'h20, 32'd0);

    // Randomized traffic, biased toward a few indices so reads hit writes
    for (int n = 0; n < 80; n++) begin
      u    = $urandom_range(0, 1);
      wr   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      a = $urandom;
      a[23:10] = '0;
      a[1:0]   = '0;
      a[9:2]   = 8'($urandom_range(0, 15));
      if (kind == 0) a[10 + $urandom_range(0, 13)] = 1'b1;
      if (kind == 1) a[1:0] = 2'($urandom_range(1, 3));
      xfer(u, wr, a, $urandom);
    end

`ifdef BFM_APBSLV_STATS_EN
    @(negedge HCLK);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("RD_COUNT u%0d", i), {16'd0, rdc[i]}, 32'(m_rd[i]));
      chk($sformatf("WR_COUNT u%0d", i), {16'd0, wrc[i]}, 32'(m_wr[i]));
      chk($sformatf("ERR_COUNT u%0d", i), {16'd0, erc[i]}, 32'(m_er[i]));
    end
    do_reset();
    @(negedge HCLK);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("RD_COUNT rst u%0d", i), {16'd0, rdc[i]}, 32'd0);
      chk($sformatf("WR_COUNT rst u%0d", i), {16'd0, wrc[i]}, 32'd0);
      chk($sformatf("ERR_COUNT rst u%0d", i), {16'd0, erc[i]}, 32'd0);
    end
`endif

    // Memory survives reset
    do_reset();
    xfer(0, 1'b0, 32'h0000_0010, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
